// File: rtl/ov7670_sccb_init.sv
// ov7670_sccb_init
//   Power-up configuration sequencer for an OV7670 sensor. A rising edge on
//   in_flag (seen while idle or done) plays a fixed register table to the
//   sensor. Each table entry is one SCCB 3-phase write: device ID, register
//   address, data. Each byte is followed by a released don't-care (ACK) bit.
//   The ACK is not checked.
//
// Ports
//   sys_clk  : system clock, rising edge
//   rst      : synchronous reset, active low
//   in_flag  : start request, rising-edge triggered
//   sccb_sdl : SIO_D, 1 = released/high (mapped to open-drain above this block)
//   sccb_scl : SIO_C
//   finish   : high once the whole table has been sent; cleared by reset or
//              by a new start
module ov7670_sccb_init #(
    parameter int          QTR      = 2,      // sys_clk cycles per SCL quarter (>=1)
    parameter logic [7:0]  DEV_ID   = 8'h42,
    parameter int          NUM_REGS = 4
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic in_flag,
    output logic sccb_sdl,
    output logic sccb_scl,
    output logic finish
);

    localparam int              CW       = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0]   QMAX     = CW'(QTR - 1);
    localparam logic [15:0]     LAST_IDX = 16'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, START, BITS, STOP, GAP, DONE} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt, cnt_n;          // sys_clk cycles within a quarter
    logic [1:0]     q, q_n;              // quarter within the current phase/bit
    logic [3:0]     bit_in, bit_n;       // 0..7 data bits, 8 = don't-care bit
    logic [1:0]     byte_sel, byte_n;    // 0 = device ID, 1 = register, 2 = data
    logic [15:0]    idx, idx_n;          // table entry
    logic           fin_n;
    logic           in_d;
    logic           tick;
    logic           start;
    logic [7:0]     cur_byte;
    logic [7:0]     sh;
    logic           tx_bit;
    logic           scl_d, sdl_d;

    // Entries past the end of the table repeat the last one.
    function automatic logic [7:0] tbl_reg(input logic [15:0] i);
        case (i)
            16'd0:   tbl_reg = 8'h12;
            16'd1:   tbl_reg = 8'h11;
            16'd2:   tbl_reg = 8'h12;
            default: tbl_reg = 8'h40;
        endcase
    endfunction

    function automatic logic [7:0] tbl_dat(input logic [15:0] i);
        case (i)
            16'd0:   tbl_dat = 8'h80;
            16'd1:   tbl_dat = 8'h01;
            16'd2:   tbl_dat = 8'h04;
            default: tbl_dat = 8'hD0;
        endcase
    endfunction

    assign tick  = (cnt == QMAX);
    assign start = in_flag && !in_d && (state == IDLE || state == DONE);

    // Bit currently on the wire: MSB first, the 9th bit of each byte released.
    always_comb begin
        case (byte_sel)
            2'd0:    cur_byte = DEV_ID;
            2'd1:    cur_byte = tbl_reg(idx);
            default: cur_byte = tbl_dat(idx);
        endcase
        sh     = cur_byte << bit_in[2:0];
        tx_bit = (bit_in == 4'd8) ? 1'b1 : sh[7];
    end

    // Next-state / counter logic
    always_comb begin
        state_n = state;
        q_n     = q;
        bit_n   = bit_in;
        byte_n  = byte_sel;
        idx_n   = idx;
        fin_n   = finish;
        if (state == IDLE || state == DONE)
            cnt_n = '0;
        else
            cnt_n = tick ? '0 : cnt + 1'b1;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = START;
                    q_n     = 2'd0;
                    idx_n   = 16'd0;
                    fin_n   = 1'b0;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (q == 2'd1) begin
                        state_n = BITS;
                        q_n     = 2'd0;
                        bit_n   = 4'd0;
                        byte_n  = 2'd0;
                    end else begin
                        q_n = q + 2'd1;
                    end
                end
            end
            BITS: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) begin
                        if (bit_in == 4'd8) begin
                            bit_n = 4'd0;
                            if (byte_sel == 2'd2)
                                state_n = STOP;
                            else
                                byte_n = byte_sel + 2'd1;
                        end else begin
                            bit_n = bit_in + 4'd1;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (q == 2'd2) begin
                        state_n = GAP;
                        q_n     = 2'd0;
                    end else begin
                        q_n = q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    q_n = q + 2'd1;
                    if (q == 2'd3) begin
                        if (idx < LAST_IDX) begin
                            idx_n   = idx + 16'd1;
                            state_n = START;
                        end else begin
                            state_n = DONE;
                            fin_n   = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pin decode from the current phase; registered below so the pins are
    // glitch-free. sdl only moves on quarter 0 of a bit, where scl is low.
    always_comb begin
        scl_d = 1'b1;
        sdl_d = 1'b1;
        case (state)
            START: begin
                scl_d = (q == 2'd0);
                sdl_d = 1'b0;
            end
            BITS: begin
                scl_d = q[1];
                sdl_d = tx_bit;
            end
            STOP: begin
                scl_d = (q != 2'd0);
                sdl_d = (q == 2'd2);
            end
            default: begin
                scl_d = 1'b1;
                sdl_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            q        <= 2'd0;
            bit_in   <= 4'd0;
            byte_sel <= 2'd0;
            idx      <= 16'd0;
            finish   <= 1'b0;
            in_d     <= 1'b0;
            sccb_scl <= 1'b1;
            sccb_sdl <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            q        <= q_n;
            bit_in   <= bit_n;
            byte_sel <= byte_n;
            idx      <= idx_n;
            finish   <= fin_n;
            in_d     <= in_flag;
            sccb_scl <= scl_d;
            sccb_sdl <= sdl_d;
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_init.sv
// Testbench for ov7670_sccb_init: a bus monitor decodes START/STOP and the
// 27 sampled bits of every write; the main sequence compares decoded frames
// against a hand-written register table and checks timing and reset cases.
module tb_ov7670_sccb_init;

    localparam int         QTR      = 2;
    localparam int         NUM_REGS = 4;
    localparam logic [7:0] DEV      = 8'h42;
    localparam int         WR_CYC   = 117 * QTR;

    logic sys_clk = 1'b0;
    logic rst     = 1'b0;
    logic in_flag = 1'b0;
    logic sccb_sdl, sccb_scl, finish;

    always #5 sys_clk = ~sys_clk;

    ov7670_sccb_init #(.QTR(QTR), .DEV_ID(DEV), .NUM_REGS(NUM_REGS)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .in_flag  (in_flag),
        .sccb_sdl (sccb_sdl),
        .sccb_scl (sccb_scl),
        .finish   (finish)
    );

    typedef struct {
        logic [7:0] reg_a;
        logic [7:0] dat;
    } vec_t;
    vec_t tbl [NUM_REGS];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    logic [26:0] frames [$];
    int          n_start = 0, n_stop = 0, proto_err = 0, hi_err = 0;
    bit          in_frame = 0;
    int          nbits = 0, hi_cnt = 0;
    logic [27:0] sr = '0;
    logic        p_scl = 1'b1, p_sdl = 1'b1;

    always @(negedge sys_clk) begin
        if (rst !== 1'b1) begin
            in_frame = 0;
            nbits    = 0;
            hi_cnt   = 0;
        end else begin
            if (p_scl && sccb_scl && p_sdl && !sccb_sdl) begin
                if (in_frame) proto_err++;
                n_start++;
                in_frame = 1;
                nbits    = 0;
                sr       = '0;
            end else if (p_scl && sccb_scl && !p_sdl && sccb_sdl) begin
                // 27 data/ack rises plus the STOP setup rise with sdl low
                if (!in_frame || nbits != 28 || sr[0] !== 1'b0) proto_err++;
                else frames.push_back(sr[27:1]);
                n_stop++;
                in_frame = 0;
            end
            if (!p_scl && sccb_scl) begin
                hi_cnt = 1;
                if (in_frame) begin
                    sr = {sr[26:0], sccb_sdl};
                    nbits++;
                end
            end else if (sccb_scl) begin
                hi_cnt++;
            end
            if (p_scl && !sccb_scl && in_frame && nbits > 0 && hi_cnt != 2 * QTR)
                hi_err++;
        end
        p_scl = sccb_scl;
        p_sdl = sccb_sdl;
    end

    function automatic logic [26:0] exp_frame(input int i);
        exp_frame = {DEV, 1'b1, tbl[i].reg_a, 1'b1, tbl[i].dat, 1'b1};
    endfunction

    // Runs until finish rises; cycle numbers count negedges after the one at
    // which in_flag was raised, minus 'skip' already consumed by the caller.
    task automatic run(input int skip, input int pulse_at, output int lat, output int start_at);
        lat      = -1;
        start_at = 0;
        for (int n = skip + 1; n < skip + 3000; n++) begin
            @(negedge sys_clk);
            if (start_at == 0 && sccb_scl === 1'b1 && sccb_sdl === 1'b0) start_at = n;
            if (pulse_at > 0 && n == pulse_at)      in_flag = 1'b0;
            if (pulse_at > 0 && n == pulse_at + 10) in_flag = 1'b1;
            if (finish === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic check_run(input string tag, input int lat, input int start_at,
                             input int base_f, input int base_s);
        chk({tag, "_start_lat"}, (start_at >= 1 && start_at <= 2), 1);
        chk({tag, "_finish_lat"},
            (lat >= NUM_REGS * WR_CYC - 2 && lat <= NUM_REGS * WR_CYC + 2) ? NUM_REGS * WR_CYC : lat,
            NUM_REGS * WR_CYC);
        chk({tag, "_stops"}, n_stop - base_s, NUM_REGS);
        chk({tag, "_frames"}, frames.size() - base_f, NUM_REGS);
        for (int i = 0; i < NUM_REGS; i++)
            if (base_f + i < frames.size())
                chk($sformatf("%s_frame%0d", tag, i), frames[base_f + i], exp_frame(i));
        chk({tag, "_proto"}, proto_err, 0);
        chk({tag, "_scl_high"}, hi_err, 0);
    endtask

    int lat, st, bf, bs, bstart;

    initial begin
        tbl[0] = '{8'h12, 8'h80};
        tbl[1] = '{8'h11, 8'h01};
        tbl[2] = '{8'h12, 8'h04};
        tbl[3] = '{8'h40, 8'hD0};

        // reset
        rst = 1'b0; in_flag = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("rst_scl", sccb_scl, 1);
        chk("rst_sdl", sccb_sdl, 1);
        chk("rst_finish", finish, 0);
        rst = 1'b1;
        repeat (20) @(negedge sys_clk);
        chk("idle_scl", sccb_scl, 1);
        chk("idle_sdl", sccb_sdl, 1);
        chk("idle_nostart", n_start, 0);

        // first run, with a second pulse mid-transmission that must be ignored
        bf = frames.size(); bs = n_stop;
        in_flag = 1'b1;
        run(0, 300, lat, st);
        check_run("run1", lat, st, bf, bs);
        in_flag = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("finish_hold", finish, 1);
        chk("done_scl", sccb_scl, 1);
        chk("done_sdl", sccb_sdl, 1);

        // restart after finish
        bf = frames.size(); bs = n_stop;
        in_flag = 1'b1;
        @(negedge sys_clk);
        chk("restart_clears_finish", finish, 0);
        run(1, 0, lat, st);
        check_run("run2", lat, st, bf, bs);

        // reset during the second write's data phase
        in_flag = 1'b0;
        repeat (3) @(negedge sys_clk);
        bs = n_stop;
        in_flag = 1'b1;
        repeat (WR_CYC + 160) @(negedge sys_clk);
        chk("mid_one_stop", n_stop - bs, 1);
        rst = 1'b0; in_flag = 1'b0;
        @(negedge sys_clk);
        chk("abort_scl", sccb_scl, 1);
        chk("abort_sdl", sccb_sdl, 1);
        chk("abort_finish", finish, 0);
        rst = 1'b1;
        bstart = n_start; bs = n_stop;
        repeat (30) @(negedge sys_clk);
        chk("abort_no_stop", n_stop - bs, 0);
        chk("abort_no_start", n_start - bstart, 0);

        bf = frames.size(); bs = n_stop;
        in_flag = 1'b1;
        run(0, 0, lat, st);
        check_run("run3", lat, st, bf, bs);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
